if_fetch_ctrl: RTL
==================

# if_fetch_ctrl

Instruction-fetch controller for the IF stage of the MIPS pipeline. It reads the current address from the PC register and issues a read to instruction memory over a req/ack handshake. It computes the next PC and drives the PC register's load enable. Fetched words go to the IF/ID boundary with a valid flag, and the block handles stalls, branch/jump redirects and the halt word.

## Interface
- NB_ADDR, 32, width of PC and memory address
- NB_INSTR, 32, instruction width
- HALT_WORD, 32'hFFFF_FFFF, fetched word that halts fetch
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset; clock i_clk
- i_pc  in  NB_ADDR  current PC from the PC register
- o_pc_next  out  NB_ADDR  value for the PC register input (combinational)
- o_pc_enable  out  1  PC register load enable (combinational)
- i_stall  in  1  hazard unit: hold IF/ID output
- i_redirect  in  1  taken branch/jump from a later stage
- i_redirect_addr  in  NB_ADDR  redirect target; bits [1:0] forced to 0
- o_mem_req  out  1  instruction memory read request
- o_mem_addr  out  NB_ADDR  read address, equal to i_pc while o_mem_req is high
- i_mem_ack  in  1  read complete; i_mem_rdata is valid this cycle
- i_mem_rdata  in  NB_INSTR  fetched word
- o_instr  out  NB_INSTR  IF/ID instruction
- o_instr_pc  out  NB_ADDR  address of o_instr
- o_instr_valid  out  1  o_instr is a live instruction
- o_halted  out  1  halt word fetched; fetch stopped

## Operation
- States:
  - IDLE: one cycle after reset.
  - REQ: request outstanding.
  - HOLD: a word is buffered while downstream is stalled.
  - HALT: terminal until reset.
- IDLE -> REQ unconditionally.
- REQ behaviour:
  - o_mem_req = 1 and o_mem_addr = i_pc, held stable until i_mem_ack.
  - A request is never cancelled.
- Ack in REQ, no pending or current redirect, i_stall = 0:
  - The word and i_pc load the output register; o_instr_valid = 1.
  - o_pc_enable = 1 and o_pc_next = i_pc + 4, modulo 2^NB_ADDR (0xFFFF_FFFC wraps to 0).
  - Stay in REQ.
- Ack in REQ with i_stall = 1:
  - The output register holds its value; the word and PC go to the skid buffer.
  - PC advances as normal; state goes to HOLD.
- HOLD:
  - No request is issued.
  - When i_stall drops, the skid buffer moves to the output register and the state goes to REQ.
- Redirect in REQ without ack:
  - Latch {i_redirect_addr & ~3} and set a pending flag; o_pc_enable = 0.
  - A later redirect overwrites the latched address (newest wins).
- Ack with pending or same-cycle redirect:
  - The word is discarded.
  - o_pc_enable = 1; o_pc_next = the same-cycle redirect address if present, otherwise the latched one.
  - The pending flag clears.
- Redirect in HOLD:
  - The skid buffer is discarded.
  - o_pc_enable = 1 with the redirect address; state goes to REQ.
- Any redirect flushes IF/ID: o_instr_valid = 0 next cycle, overriding i_stall.
- Halt word accepted (not discarded):
  - It is delivered as a valid instruction.
  - PC is not advanced; state goes to HALT and o_halted = 1 next cycle.
- HALT:
  - Redirects and stalls are ignored except that i_stall still holds the output register.
  - No requests are issued.
- i_stall = 0 with no new word: o_instr_valid = 0 next cycle (bubble).

## Timing
- Reset: all of the following are 0 on the cycle after i_reset is sampled high; the state is IDLE.
  - o_mem_req, o_pc_enable, o_pc_next, o_instr, o_instr_pc, o_instr_valid, o_halted.
  - The skid buffer and the pending flag.
- First o_mem_req is asserted in the second cycle after i_reset falls.
- Reset mid-request: the request drops immediately, and a late i_mem_ack is ignored in IDLE.
- Latency: ack in cycle N produces o_instr_valid in N+1 and the new i_pc in N+1.
- Throughput: 1 instr/cycle when memory acks in the request cycle.
- o_pc_enable is high only in an ack cycle or a HOLD redirect cycle.

## Structure
- Package mips_if_pkg holds:
  - the state enum (IDLE, REQ, HOLD, HALT);
  - PC_STEP = 4;
  - HALT_WORD default;
  - NB_ADDR / NB_INSTR defaults.
- Sub-module if_instr_buffer holds the output register plus the single-entry skid buffer, with load, hold and flush controls.
- The FSM, next-PC mux and redirect latch stay in if_fetch_ctrl.

## Test plan
- Reset, then zero-wait memory returning 0x2001_0005, 0x2002_0006 -> o_instr_pc 0, 4 on consecutive cycles; o_pc_enable high each ack cycle.
- Ack delayed 3 cycles -> o_mem_addr stable for 4 cycles; one valid instruction at the cycle after the ack.
- Redirect to 0x40 two cycles before a delayed ack -> fetched word dropped, o_instr_valid 0, next o_mem_addr 0x40.
- i_stall high across an ack at PC 8 -> output holds the PC 4 instruction; when the stall drops, PC 8 appears; no extra request is issued while in HOLD.
- Redirect to 0x103 during HOLD -> skid buffer discarded, o_pc_next 0x100, o_instr_valid 0 next cycle.
- Halt word 0xFFFF_FFFF at PC 0xC, then a redirect -> delivered valid, o_halted 1, no further o_mem_req, PC stays 0xC; reset clears everything.

Source files
------------

// File: rtl/mips_if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_if_pkg;

  localparam int          NB_ADDR_DEF   = 32;
  localparam int          NB_INSTR_DEF  = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam int          PC_STEP       = 4;

  // IDLE: one cycle after reset; REQ: read outstanding;
  // HOLD: word parked in the skid buffer; HALT: terminal until reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_instr_buffer.sv
// IF/ID output register with a single-entry skid buffer.
// load  : a fetched word is presented this cycle
// hold  : downstream stall, output register must not change
// flush : drop both the output and the skid entry
module if_instr_buffer
  import mips_if_pkg::*;
#(
  parameter int NB_ADDR  = NB_ADDR_DEF,
  parameter int NB_INSTR = NB_INSTR_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                load,
  input  logic                hold,
  input  logic                flush,
  input  logic [NB_INSTR-1:0] load_instr,
  input  logic [NB_ADDR-1:0]  load_pc,
  output logic [NB_INSTR-1:0] instr,
  output logic [NB_ADDR-1:0]  instr_pc,
  output logic                instr_valid
);

  logic [NB_INSTR-1:0] skid_instr;
  logic [NB_ADDR-1:0]  skid_pc;
  logic                skid_valid;

  // Output/skid update: flush beats everything, a parked word drains first,
  // a new word goes to the skid while stalled, otherwise a bubble is inserted.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      // NOTE: data registers are reset too because the IF/ID outputs must read zero after reset.
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      skid_valid  <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (skid_valid) begin
      if (!hold) begin
        instr       <= skid_instr;
        instr_pc    <= skid_pc;
        instr_valid <= 1'b1;
        skid_valid  <= 1'b0;
      end
    end else if (load) begin
      if (hold) begin
        skid_instr <= load_instr;
        skid_pc    <= load_pc;
        skid_valid <= 1'b1;
      end else begin
        instr       <= load_instr;
        instr_pc    <= load_pc;
        instr_valid <= 1'b1;
      end
    end else if (!hold) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives the memory read handshake, selects the
// next PC (sequential, redirect, or hold) and feeds the IF/ID buffer.
module if_fetch_ctrl
  import mips_if_pkg::*;
#(
  parameter int                 NB_ADDR   = NB_ADDR_DEF,
  parameter int                 NB_INSTR  = NB_INSTR_DEF,
  parameter logic [NB_INSTR-1:0] HALT_WORD = NB_INSTR'(HALT_WORD_DEF)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_ADDR-1:0]  i_pc,
  output logic [NB_ADDR-1:0]  o_pc_next,
  output logic                o_pc_enable,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [NB_ADDR-1:0]  i_redirect_addr,
  output logic                o_mem_req,
  output logic [NB_ADDR-1:0]  o_mem_addr,
  input  logic                i_mem_ack,
  input  logic [NB_INSTR-1:0] i_mem_rdata,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_ADDR-1:0]  o_instr_pc,
  output logic                o_instr_valid,
  output logic                o_halted
);

  fetch_state_e       state, state_next;
  logic               pend_valid, pend_valid_next;
  logic [NB_ADDR-1:0] pend_addr, pend_addr_next;

  logic               mem_req;
  logic               pc_en;
  logic [NB_ADDR-1:0] pc_next;
  logic               buf_load;
  logic               buf_flush;

  logic [NB_ADDR-1:0] redir_addr;
  logic [NB_ADDR-1:0] pc_inc;
  logic               is_halt;

  // Redirect targets are word aligned; sequential PC wraps modulo 2^NB_ADDR.
  assign redir_addr = i_redirect_addr & ~NB_ADDR'(3);
  assign pc_inc     = i_pc + NB_ADDR'(PC_STEP);
  assign is_halt    = (i_mem_rdata == HALT_WORD);

  // State and pending-redirect registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      state      <= state_next;
      pend_valid <= pend_valid_next;
      pend_addr  <= pend_addr_next;
    end
  end

  // Next-state, next-PC mux, redirect latch and buffer controls.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_next      = state;
    pend_valid_next = pend_valid;
    pend_addr_next  = pend_addr;
    mem_req         = 1'b0;
    pc_en           = 1'b0;
    pc_next         = '0;
    buf_load        = 1'b0;
    buf_flush       = 1'b0;

    case (state)
      IDLE: state_next = REQ;

      REQ: begin
        mem_req = 1'b1;
        if (i_redirect) buf_flush = 1'b1;
        if (i_mem_ack) begin
          pend_valid_next = 1'b0;
          if (i_redirect) begin
            // Wrong-path word: drop it, same-cycle redirect has priority.
            pc_en   = 1'b1;
            pc_next = redir_addr;
          end else if (pend_valid) begin
            pc_en   = 1'b1;
            pc_next = pend_addr;
          end else begin
            buf_load = 1'b1;
            if (is_halt) begin
              // Halt word is delivered but the PC stays on it.
              state_next = HALT;
            end else begin
              pc_en   = 1'b1;
              pc_next = pc_inc;
              if (i_stall) state_next = HOLD;
            end
          end
        end else if (i_redirect) begin
          // The request cannot be cancelled, so remember the newest target.
          pend_valid_next = 1'b1;
          pend_addr_next  = redir_addr;
        end
      end

      HOLD: begin
        if (i_redirect) begin
          buf_flush  = 1'b1;
          pc_en      = 1'b1;
          pc_next    = redir_addr;
          state_next = REQ;
        end else if (!i_stall) begin
          state_next = REQ;
        end
      end

      HALT: state_next = HALT;

      default: state_next = IDLE;
    endcase
  end

  // Handshake and PC load are suppressed while reset is asserted.
  assign o_mem_req   = mem_req & ~i_reset;
  assign o_mem_addr  = o_mem_req ? i_pc : '0;
  assign o_pc_enable = pc_en & ~i_reset;
  assign o_pc_next   = pc_next;
  assign o_halted    = (state == HALT);

  if_instr_buffer #(
    .NB_ADDR  (NB_ADDR),
    .NB_INSTR (NB_INSTR)
  ) u_instr_buffer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .load        (buf_load),
    .hold        (i_stall),
    .flush       (buf_flush),
    .load_instr  (i_mem_rdata),
    .load_pc     (i_pc),
    .instr       (o_instr),
    .instr_pc    (o_instr_pc),
    .instr_valid (o_instr_valid)
  );

endmodule
